// File: rtl/seq_scan_ctrl.sv
// Scan controller: serializes a latched word LSB-first and runs
// overlapping pattern detection with hit count and first-hit index.
module seq_scan_ctrl #(
   parameter int WORD_W = 16,
   parameter int PAT_W  = 3,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_in,
   input  logic [PAT_W-1:0]  pattern,
   output logic              ready,
   output logic              busy,
   output logic              ser_bit,
   output logic              ser_valid,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  first_hit,
   output logic              first_valid,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] MIN_IDX  = CNT_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic              hit_q, hit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  first_q, first_d;
   logic              fv_q, fv_d;

   logic [WORD_W-1:0] word_sh;
   logic              cur_bit;
   logic [PAT_W-1:0]  window;
   logic              match;

   // Shift keeps the index select width-agnostic.
   assign word_sh = word_q >> idx_q;
   assign cur_bit = word_sh[0];
   assign window  = {hist_q, cur_bit};
   assign match   = (window == pat_q) && (idx_q >= MIN_IDX);

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      idx_d   = idx_q;
      hit_d   = 1'b0;
      cnt_d   = cnt_q;
      first_d = first_q;
      fv_d    = fv_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               word_d  = word_in;
               pat_d   = pattern;
               hist_d  = '0;
               idx_d   = '0;
               cnt_d   = '0;
               first_d = '0;
               fv_d    = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            hist_d = window[PAT_W-2:0];
            idx_d  = idx_q + CNT_W'(1);
            if (match) begin
               hit_d = 1'b1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (!fv_q) begin
                  first_d = idx_q;
                  fv_d    = 1'b1;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            word_d  = '0;
            pat_d   = '0;
            hist_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
            first_d = '0;
            fv_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         pat_q   <= '0;
         hist_q  <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
         first_q <= '0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         fv_q    <= fv_d;
      end
   end

   assign ready       = (state_q == S_IDLE);
   assign busy        = (state_q == S_SHIFT) || (state_q == S_DONE);
   assign ser_valid   = (state_q == S_SHIFT);
   assign ser_bit     = ser_valid & cur_bit;
   assign done        = (state_q == S_DONE);
   assign hit         = hit_q;
   assign hit_count   = cnt_q;
   assign first_hit   = first_q;
   assign first_valid = fv_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: per-bit scoreboard of serial
// bits and hits, plus end-of-scan result checks.
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] word_in;
   logic [2:0]  pattern;
   logic        ready, busy, ser_bit, ser_valid, hit;
   logic [4:0]  hit_count, first_hit;
   logic        first_valid, done;

   int nvec = 0;
   int nerr = 0;

   logic exp_bit[$];
   logic exp_hit[$];

   seq_scan_ctrl #(.WORD_W(16), .PAT_W(3), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start),
      .word_in(word_in), .pattern(pattern),
      .ready(ready), .busy(busy),
      .ser_bit(ser_bit), .ser_valid(ser_valid),
      .hit(hit), .hit_count(hit_count),
      .first_hit(first_hit), .first_valid(first_valid),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Window ending at bit i, oldest first, compared to the pattern.
   function automatic logic mdl_hit(input logic [15:0] w,
                                    input logic [2:0] p, input int i);
      if (i < 2) return 1'b0;
      return (w[i-2] == p[2]) && (w[i-1] == p[1]) && (w[i] == p[0]);
   endfunction

   // mode: 0 plain, 1 ignored start at idx 7,
   // 2 start held from idx 14, 3 reset abort at idx 5
   task automatic run_scan(input logic [15:0] w, input logic [2:0] p,
                           input int ecnt, input int efirst,
                           input int efv, input int mode);
      logic b, h;
      @(negedge clk);
      word_in = w;
      pattern = p;
      start   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_bit.push_back(w[i]);
         exp_hit.push_back(mdl_hit(w, p, i));
      end
      @(posedge clk);
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k < 16) begin
            chk("ser_valid", ser_valid, 1);
            chk("ready_busy", {ready, busy}, 2'b01);
            chk("done_early", done, 0);
            b = exp_bit.pop_front();
            chk($sformatf("ser_bit[%0d]", k), ser_bit, b);
         end
         if (k >= 1) begin
            h = exp_hit.pop_front();
            chk($sformatf("hit[%0d]", k - 1), hit, h);
         end else begin
            chk("hit_first_cycle", hit, 0);
         end
         if (k == 16) begin
            chk("done", done, 1);
            chk("done_ser_valid", ser_valid, 0);
            chk("done_ready_busy", {ready, busy}, 2'b01);
            chk("hit_count", hit_count, ecnt);
            chk("first_hit", first_hit, efirst);
            chk("first_valid", first_valid, efv);
         end
         if (mode == 1 && k == 7) begin
            start = 1'b1; word_in = 16'hFFFF; pattern = 3'b111;
         end
         if (mode == 1 && k == 8) start = 1'b0;
         if (mode == 2 && k == 14) begin
            start = 1'b1; word_in = 16'hFFFF; pattern = 3'b111;
         end
         if (mode == 3 && k == 5) begin
            #2 rst = 1'b0;
            #1;
            chk("abort_ready", ready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_ser_valid", ser_valid, 0);
            chk("abort_hit_count", hit_count, 0);
            chk("abort_first_valid", first_valid, 0);
            chk("abort_hit", hit, 0);
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("abort_no_done", done, 0);
            end
            rst = 1'b1;
            exp_bit.delete();
            exp_hit.delete();
            return;
         end
      end
   endtask

   initial begin
      int n;
      rst     = 1'b0;
      start   = 1'b0;
      word_in = '0;
      pattern = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_hit_done", {hit, done}, 0);
      chk("rst_count", {hit_count, first_hit, first_valid}, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_hold", {ready, busy}, 2'b10);

      run_scan(16'b0101011101111000, 3'b000, 1, 2, 1, 0);
      run_scan(16'h0000, 3'b000, 14, 2, 1, 0);
      run_scan(16'hFFFF, 3'b000, 0, 0, 0, 0);
      run_scan(16'h0015, 3'b101, 2, 2, 1, 0);

      @(negedge clk);
      chk("idle_results_kept", {hit_count, first_hit}, {5'd2, 5'd2});
      chk("idle_ready", ready, 1);

      run_scan(16'b0101011101111000, 3'b000, 1, 2, 1, 3);
      run_scan(16'b0101011101111000, 3'b000, 1, 2, 1, 0);

      run_scan(16'h0000, 3'b000, 14, 2, 1, 1);

      run_scan(16'hFFFF, 3'b000, 0, 0, 0, 2);
      @(negedge clk);
      chk("hold_idle_ready", ready, 1);
      chk("hold_idle_busy", busy, 0);
      chk("hold_idle_hit", hit, 0);
      @(negedge clk);
      start = 1'b0;
      chk("hold_accept_busy", busy, 1);
      chk("hold_accept_ser_valid", ser_valid, 1);
      chk("hold_accept_clear", {hit_count, first_valid}, 0);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold_done_seen", done, 1);
      chk("hold_hit_count", hit_count, 14);
      chk("hold_first_hit", first_hit, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
